// File: rtl/mem_request_sequencer.sv
// mem_request_sequencer
// Initiator-side front end for the unified Memory block. Takes one load/store
// request at a time from the MEM stage, issues it to Memory as one aligned beat
// or as a run of little-endian BYTE beats (misaligned HALFWORD/WORD), reassembles
// and extends split loads, and returns the result over a response handshake.
//
// Mode encoding (MemoryModesPackage): NONE=0, BYTE=1, HALFWORD=2, WORD=3,
// WORDLEFT=4, WORDRIGHT=5. WORDLEFT/WORDRIGHT are passed through as one beat.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqValid/reqReady            request handshake (reqReady only in IDLE)
//   reqWrite, reqMode,           request payload: store flag, access mode,
//   reqUnsigned, reqAddress,     zero-extend flag, byte address,
//   reqData                      right-justified store data
//   respValid/respReady          response handshake
//   respData, respError          load result (0 for stores), misaligned reject
//   address, data, writeMode,    registered beat presented to Memory
//   readMode, unsignedLoad
//   dataOutput                   Memory read data, valid the cycle after a beat
module mem_request_sequencer #(
  parameter int unsigned ALLOW_MISALIGNED = 1,
  parameter int unsigned ADDR_W           = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [2:0]        reqMode,
  input  logic              reqUnsigned,
  input  logic [ADDR_W-1:0] reqAddress,
  input  logic [31:0]       reqData,
  output logic              respValid,
  input  logic              respReady,
  output logic [31:0]       respData,
  output logic              respError,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data,
  output logic [2:0]        writeMode,
  output logic [2:0]        readMode,
  output logic              unsignedLoad,
  input  logic [31:0]       dataOutput
);

  localparam logic [2:0] MODE_NONE     = 3'd0;
  localparam logic [2:0] MODE_BYTE     = 3'd1;
  localparam logic [2:0] MODE_HALFWORD = 3'd2;
  localparam logic [2:0] MODE_WORD     = 3'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

  stateT             state;
  logic              reqWriteQ;
  logic [2:0]        reqModeQ;
  logic              reqUnsignedQ;
  logic [ADDR_W-1:0] reqAddressQ;
  logic [31:0]       reqDataQ;
  logic              splitQ;
  logic [1:0]        lastBeat;
  logic [1:0]        beatIdx;
  logic [31:0]       asm;

  // Request decode at acceptance
  logic       reqMisaligned;
  logic       acceptNone;
  logic       acceptSplit;
  logic       acceptReject;
  logic [1:0] acceptLast;

  always_comb begin
    reqMisaligned = 1'b0;
    if (reqMode == MODE_HALFWORD) begin
      reqMisaligned = reqAddress[0];
    end else if (reqMode == MODE_WORD) begin
      reqMisaligned = (reqAddress[1:0] != 2'b00);
    end
    acceptNone   = (reqMode == MODE_NONE);
    acceptSplit  = reqMisaligned && (ALLOW_MISALIGNED != 0);
    acceptReject = reqMisaligned && (ALLOW_MISALIGNED == 0);
    acceptLast   = 2'd0;
    if (acceptSplit) begin
      acceptLast = (reqMode == MODE_WORD) ? 2'd3 : 2'd1;
    end
  end

  // Next beat to present: beat 0 comes straight from the request inputs,
  // later beats from the latched copy.
  logic              srcWrite;
  logic [2:0]        srcMode;
  logic              srcUnsigned;
  logic [ADDR_W-1:0] srcAddress;
  logic [31:0]       srcData;
  logic              srcSplit;
  logic [1:0]        beatK;
  logic [7:0]        beatByte;
  logic [ADDR_W-1:0] beatAddress;
  logic [31:0]       beatData;
  logic [2:0]        beatMode;
  logic              beatUnsigned;
  logic              launchBeat;

  always_comb begin
    srcWrite    = reqWriteQ;
    srcMode     = reqModeQ;
    srcUnsigned = reqUnsignedQ;
    srcAddress  = reqAddressQ;
    srcData     = reqDataQ;
    srcSplit    = splitQ;
    beatK       = beatIdx + 2'd1;
    if (state == IDLE) begin
      srcWrite    = reqWrite;
      srcMode     = reqMode;
      srcUnsigned = reqUnsigned;
      srcAddress  = reqAddress;
      srcData     = reqData;
      srcSplit    = acceptSplit;
      beatK       = 2'd0;
    end
    beatByte = 8'(srcData >> {beatK, 3'b000});
    if (srcSplit) begin
      beatAddress  = srcAddress + ADDR_W'(beatK);
      beatData     = {24'd0, beatByte};
      beatMode     = MODE_BYTE;
      beatUnsigned = 1'b1;
    end else begin
      beatAddress  = srcAddress;
      beatData     = srcData;
      beatMode     = srcMode;
      beatUnsigned = srcUnsigned;
    end
    launchBeat = ((state == IDLE) && reqValid && !acceptNone && !acceptReject) ||
                 ((state == ISSUE) && (beatIdx != lastBeat));
  end

  // Byte reassembly: in ISSUE the previous beat's data arrives, in WAIT the last.
  logic [1:0]  capIdx;
  logic [31:0] asmNext;
  logic [31:0] loadResult;

  always_comb begin
    capIdx  = (state == WAIT) ? beatIdx : beatIdx - 2'd1;
    asmNext = asm;
    asmNext[{capIdx, 3'b000} +: 8] = dataOutput[7:0];
    if (!splitQ) begin
      loadResult = dataOutput;
    end else if (reqModeQ == MODE_HALFWORD) begin
      loadResult = reqUnsignedQ ? {16'd0, asmNext[15:0]} : {{16{asmNext[15]}}, asmNext[15:0]};
    end else begin
      loadResult = asmNext;
    end
  end

  // Sequencer state, response and Memory-side registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      reqReady     <= 1'b1;
      respValid    <= 1'b0;
      respData     <= '0;
      respError    <= 1'b0;
      address      <= '0;
      data         <= '0;
      writeMode    <= MODE_NONE;
      readMode     <= MODE_NONE;
      unsignedLoad <= 1'b0;
      reqWriteQ    <= 1'b0;
      reqModeQ     <= MODE_NONE;
      reqUnsignedQ <= 1'b0;
      reqAddressQ  <= '0;
      reqDataQ     <= '0;
      splitQ       <= 1'b0;
      lastBeat     <= 2'd0;
      beatIdx      <= 2'd0;
      asm          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid && reqReady) begin
            reqWriteQ    <= reqWrite;
            reqModeQ     <= reqMode;
            reqUnsignedQ <= reqUnsigned;
            reqAddressQ  <= reqAddress;
            reqDataQ     <= reqData;
            splitQ       <= acceptSplit;
            lastBeat     <= acceptLast;
            beatIdx      <= 2'd0;
            asm          <= '0;
            reqReady     <= 1'b0;
            if (acceptNone || acceptReject) begin
              state     <= RESP;
              respValid <= 1'b1;
              respData  <= '0;
              respError <= acceptReject;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!reqWriteQ && (beatIdx != 2'd0)) begin
            asm <= asmNext;
          end
          if (beatIdx == lastBeat) begin
            if (reqWriteQ) begin
              state     <= RESP;
              respValid <= 1'b1;
              respData  <= '0;
            end else begin
              state <= WAIT;
            end
          end else begin
            beatIdx <= beatIdx + 2'd1;
          end
        end
        WAIT: begin
          state     <= RESP;
          respValid <= 1'b1;
          respData  <= loadResult;
        end
        RESP: begin
          if (respReady) begin
            state     <= IDLE;
            reqReady  <= 1'b1;
            respValid <= 1'b0;
            respData  <= '0;
            respError <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Memory sees NONE/0 in every cycle without a beat
      if (launchBeat) begin
        address      <= beatAddress;
        data         <= beatData;
        writeMode    <= srcWrite ? beatMode : MODE_NONE;
        readMode     <= srcWrite ? MODE_NONE : beatMode;
        unsignedLoad <= beatUnsigned;
      end else begin
        address      <= '0;
        data         <= '0;
        writeMode    <= MODE_NONE;
        readMode     <= MODE_NONE;
        unsignedLoad <= 1'b0;
      end
    end
  end

endmodule
